datapath_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4-bit accumulator datapath. It drives the datapath's ABus, SelB, LoadAC and AddAlu.
It accepts one instruction at a time over a valid/ready handshake. Each instruction carries an opcode, a DATA_W-bit immediate and a repeat count.
It issues one load cycle per repetition, with a gap cycle between repetitions, then pulses done.

---
 rtl/dp_ctrl_pkg.sv | 37 +++
 rtl/dp_op_decode.sv | 35 +++
 rtl/datapath_ctrl.sv | 113 +++++++++++
 tb/tb_datapath_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the accumulator-datapath sequencer:
// opcodes, state encodings and the control-word layout.
package dp_ctrl_pkg;

  // Instruction opcodes
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_DBL  = 2'b11;

  // Sequencer state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Datapath control word, packed as {SelB, AddAlu, LoadAC}
  typedef struct packed {
    logic sel_b;
    logic add_alu;
    logic load_ac;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_OFF = '{sel_b: 1'b0, add_alu: 1'b0, load_ac: 1'b0};

  // Assemble a control word from its three fields
  function automatic ctrl_word_t make_ctrl(input logic sel_b,
                                           input logic add_alu,
                                           input logic load_ac);
    ctrl_word_t w;
    w.sel_b   = sel_b;
    w.add_alu = add_alu;
    w.load_ac = load_ac;
    return w;
  endfunction

endpackage

// File: rtl/dp_op_decode.sv
// Opcode to datapath-routing map used while an instruction is executing.
// LDI loads the immediate, ADDI adds the immediate, DBL adds AC to itself.
module dp_op_decode
  import dp_ctrl_pkg::*;
(
  input  logic [1:0] op_i,
  output logic       sel_b_o,
  output logic       add_alu_o
);

  // Pure table lookup; NOP never reaches EXEC/GAP so its entry is inert
  always_comb begin
    sel_b_o   = 1'b0;
    add_alu_o = 1'b0;
    case (op_i)
      OP_LDI: begin
        sel_b_o   = 1'b1;
        add_alu_o = 1'b0;
      end
      OP_ADDI: begin
        sel_b_o   = 1'b1;
        add_alu_o = 1'b1;
      end
      OP_DBL: begin
        sel_b_o   = 1'b0;
        add_alu_o = 1'b1;
      end
      default: begin
        sel_b_o   = 1'b0;
        add_alu_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer driving the 4-bit accumulator datapath.
// Accepts one instruction in IDLE, issues rep+1 load cycles separated by
// a settle (GAP) cycle, then pulses done. All outputs decode registered state.
module datapath_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int REP_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic [REP_W-1:0]  instr_rep,
  output logic [DATA_W-1:0] ABus,
  output logic              SelB,
  output logic              LoadAC,
  output logic              AddAlu,
  output logic              busy,
  output logic              done
);

  localparam logic [REP_W-1:0] CNT_ZERO = '0;
  localparam logic [REP_W-1:0] CNT_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;

  logic       dec_sel_b;
  logic       dec_add_alu;
  ctrl_word_t ctrl;

  dp_op_decode u_op_decode (
    .op_i      (op_q),
    .sel_b_o   (dec_sel_b),
    .add_alu_o (dec_add_alu)
  );

  // Next-state logic: instruction fields are captured only on the IDLE accept
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          imm_d   = instr_imm;
          cnt_d   = instr_rep;
          state_d = (instr_op == OP_NOP) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        // Counter only decrements from nonzero, so it can never wrap
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // One cycle with LoadAC low so the datapath's OutBus settles
        state_d = S_EXEC;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and instruction registers; reset wins over any accept in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode of the datapath control word; GAP holds routing but drops the load
  always_comb begin
    ctrl = CTRL_OFF;
    case (state_q)
      S_EXEC:  ctrl = make_ctrl(dec_sel_b, dec_add_alu, 1'b1);
      S_GAP:   ctrl = make_ctrl(dec_sel_b, dec_add_alu, 1'b0);
      default: ctrl = CTRL_OFF;
    endcase
  end

  assign SelB        = ctrl.sel_b;
  assign AddAlu      = ctrl.add_alu;
  assign LoadAC      = ctrl.load_ac;
  assign ABus        = imm_q;
  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a small accumulator model attached
// to its control outputs.
module tb_datapath_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [1:0] instr_op;
  logic [3:0] instr_imm;
  logic [1:0] instr_rep;
  logic       instr_ready;
  logic [3:0] ABus;
  logic       SelB;
  logic       LoadAC;
  logic       AddAlu;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  datapath_ctrl #(.DATA_W(4), .REP_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_imm   (instr_imm),
    .instr_rep   (instr_rep),
    .ABus        (ABus),
    .SelB        (SelB),
    .LoadAC      (LoadAC),
    .AddAlu      (AddAlu),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Accumulator datapath model
  logic [3:0] ac = 4'h0;
  logic [3:0] bbus;
  assign bbus = SelB ? ABus : ac;
  always @(posedge clock) begin
    if (LoadAC) ac <= AddAlu ? (ac + bbus) : bbus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run one instruction and check every cycle until the following IDLE.
  // Expected routing per opcode is hand-tabulated here.
  task automatic run_instr(input logic [1:0] op, input logic [3:0] imm,
                           input logic [1:0] rep, input bit hold_valid);
    int  n;
    int  loads;
    logic exp_sel, exp_add, exp_load, active;
    loads = 0;
    case (op)
      2'b01:   begin exp_sel = 1'b1; exp_add = 1'b0; end
      2'b10:   begin exp_sel = 1'b1; exp_add = 1'b1; end
      2'b11:   begin exp_sel = 1'b0; exp_add = 1'b1; end
      default: begin exp_sel = 1'b0; exp_add = 1'b0; end
    endcase
    check("ready_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_imm   = imm;
    instr_rep   = rep;
    step();
    if (!hold_valid) instr_valid = 1'b0;
    // Disturb the inputs: they must be ignored while busy
    instr_op  = 2'b01;
    instr_imm = ~imm;
    instr_rep = ~rep;
    n = (op == 2'b00) ? 1 : 2 + 2 * int'(rep);
    for (int i = 1; i <= n; i++) begin
      exp_load = (op != 2'b00) && (i % 2 == 1) && (i <= 1 + 2 * int'(rep));
      active   = (op != 2'b00) && (i < n);
      check("load",   LoadAC, exp_load);
      check("done",   done, (i == n));
      check("busy",   busy, 1);
      check("ready",  instr_ready, 0);
      check("abus",   ABus, imm);
      check("selb",   SelB, active ? exp_sel : 1'b0);
      check("addalu", AddAlu, active ? exp_add : 1'b0);
      if (LoadAC) loads++;
      step();
    end
    instr_valid = 1'b0;
    check("ready_after", instr_ready, 1);
    check("busy_after",  busy, 0);
    check("done_after",  done, 0);
    $display("instr op=%0d imm=%h rep=%0d loads=%0d ac=%h", op, imm, rep, loads, ac);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 2'b00;
    instr_imm   = 4'h0;
    instr_rep   = 2'd0;
    step();
    step();
    reset = 1'b0;
    check("rst_ready",  instr_ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_load",   LoadAC, 0);
    check("rst_abus",   ABus, 0);
    check("rst_selb",   SelB, 0);
    check("rst_addalu", AddAlu, 0);
    step();
    check("idle_stays", busy, 0);

    run_instr(2'b01, 4'hF, 2'd0, 1'b0);   // LDI F
    check("ac_ldi", ac, 4'hF);
    run_instr(2'b10, 4'h6, 2'd0, 1'b0);   // ADDI 6 -> 5
    check("ac_addi", ac, 4'h5);
    run_instr(2'b01, 4'h1, 2'd0, 1'b0);   // LDI 1
    run_instr(2'b11, 4'h0, 2'd2, 1'b0);   // DBL x3 -> 8
    check("ac_dbl", ac, 4'h8);
    run_instr(2'b00, 4'h9, 2'd3, 1'b1);   // NOP with valid held high
    check("ac_nop", ac, 4'h8);
    run_instr(2'b10, 4'h1, 2'd3, 1'b0);   // ADDI 1 x4 -> C
    check("ac_addi_x4", ac, 4'hC);

    // Reset has priority over an accept in the same cycle
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr_op    = 2'b01;
    instr_imm   = 4'hA;
    instr_rep   = 2'd0;
    step();
    reset       = 1'b0;
    instr_valid = 1'b0;
    check("prio_busy",  busy, 0);
    check("prio_ready", instr_ready, 1);
    check("prio_abus",  ABus, 0);
    check("prio_load",  LoadAC, 0);
    step();
    check("prio_busy2", busy, 0);

    // Reset during the second EXEC of ADDI rep=3
    instr_valid = 1'b1;
    instr_op    = 2'b10;
    instr_imm   = 4'h3;
    instr_rep   = 2'd3;
    step();
    instr_valid = 1'b0;
    check("int_exec1", LoadAC, 1);
    step();
    check("int_gap", LoadAC, 0);
    step();
    check("int_exec2", LoadAC, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("int_load",  LoadAC, 0);
    check("int_busy",  busy, 0);
    check("int_done",  done, 0);
    check("int_ready", instr_ready, 1);
    check("int_abus",  ABus, 0);
    for (int i = 0; i < 6; i++) begin
      check("int_no_done", done, 0);
      check("int_no_load", LoadAC, 0);
      step();
    end
    $display("instr op=2 imm=3 rep=3 abandoned by reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
